// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed/unsigned per operation.
// Define MULT_SEQ_EARLY_EN to end CALC as soon as the remaining multiplier bits are all zero.
module mult_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               sign,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] z
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [PW-1:0]    mcand;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    acc_next;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] mplier_next;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [CW-1:0]    count;
   logic             neg;
   logic             last;

   always_comb begin
      // Negating the most-negative value wraps back to 2^(WIDTH-1), the correct unsigned magnitude.
      a_mag       = (sign && a[WIDTH-1]) ? -a : a;
      b_mag       = (sign && b[WIDTH-1]) ? -b : b;
      acc_next    = mplier[0] ? (acc + mcand) : acc;
      mplier_next = mplier >> 1;
`ifdef MULT_SEQ_EARLY_EN
      last        = (mplier_next == '0);
`else
      last        = (count == CW'(WIDTH - 1));
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         z      <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         neg    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand  <= {{WIDTH{1'b0}}, a_mag};
                  mplier <= b_mag;
                  neg    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc    <= '0;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= CALC;
               end else begin
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            CALC: begin
               // The multiplicand register is shifted each step, so it always holds |a| << count.
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier_next;
               count  <= count + 1'b1;
               if (last) begin
                  z     <= neg ? -acc_next : acc_next;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq at WIDTH=32; honours MULT_SEQ_EARLY_EN when defined.
module tb_mult_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        sign;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [63:0] z;

   int n_checks = 0;
   int n_fail   = 0;

   mult_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .sign(sign),
      .a(a), .b(b), .busy(busy), .done(done), .z(z)
   );

   always #5 clk = ~clk;

`ifdef MULT_SEQ_EARLY_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   // Called at a negedge; returns at the negedge where done is high (or after a timeout).
   task automatic run_op(input logic s, input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output int bcnt);
      start = 1'b1; sign = s; a = av; b = bv;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; a = '0; b = '0; sign = 1'b0;
      lat = 0; bcnt = 0;
      while (!done && lat < 200) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL timeout: done=%b after %0d cycles, required 1", done, lat);
      end
   endtask

   task automatic check_z(input string name, input logic [63:0] exp);
      n_checks++;
      if (z !== exp) begin
         n_fail++;
         $display("FAIL %s: z=%h required %h", name, z, exp);
      end
   endtask

   task automatic check_lat(input string name, input int lat, input int exp);
      n_checks++;
      if (lat !== exp) begin
         n_fail++;
         $display("FAIL %s latency: got %0d required %0d", name, lat, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; sign = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, z} !== 66'd0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b z=%h required 0 0 0", busy, done, z);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned_max();
      int lat, bcnt;
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
      check_z("unsigned_max", 64'hFFFF_FFFE_0000_0001);
      check_lat("unsigned_max", lat, 32);
      n_checks++;
      if (bcnt !== 32 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_span: busy cycles=%0d busy_in_done=%b required 32 0", bcnt, busy);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || z !== 64'hFFFF_FFFE_0000_0001) begin
         n_fail++;
         $display("FAIL done_pulse_hold: done=%b z=%h required 0 fffffffe00000001", done, z);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bcnt;
      run_op(1'b1, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
      check_z("signed_neg3x5", 64'hFFFF_FFFF_FFFF_FFF1);
      check_lat("signed_neg3x5", lat, EARLY ? 3 : 32);
      run_op(1'b1, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
      check_z("b2b_minmin", 64'h4000_0000_0000_0000);
      check_lat("b2b_minmin", lat, 32);
      @(negedge clk);
   endtask

   task automatic test_sign_mode();
      int lat, bcnt;
      run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
      check_z("signed_m1xm1", 64'd1);
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
      check_z("unsigned_after_signed", 64'hFFFF_FFFE_0000_0001);
      run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFA, lat, bcnt);
      check_z("signed_7xm6", 64'hFFFF_FFFF_FFFF_FFD6);
      @(negedge clk);
   endtask

   task automatic test_busy_ignore();
      int lat;
      int ign = EARLY ? 2 : 10;
      start = 1'b1; sign = 1'b0; a = 32'd7; b = 32'd9;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 200) begin
         if (lat == ign) begin
            start = 1'b1; a = 32'd2; b = 32'd2;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check_z("busy_ignore", 64'd63);
      check_lat("busy_ignore", lat, EARLY ? 4 : 32);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_ignore_idle: busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      start = 1'b1; sign = 1'b0; a = 32'd11; b = 32'hFFFF_0000;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if ({busy, done, z} !== 66'd0) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b done=%b z=%h required 0 0 0", busy, done, z);
      end
      repeat (40) begin
         @(negedge clk);
         if (done) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_no_done: done pulses=%0d required 0", seen);
      end
   endtask

   task automatic test_latency();
      int lat, bcnt;
      run_op(1'b0, 32'd123, 32'd1, lat, bcnt);
      check_z("lat_b1", 64'd123);
      check_lat("lat_b1", lat, EARLY ? 1 : 32);
      @(negedge clk);
      run_op(1'b0, 32'd3, 32'h0001_0000, lat, bcnt);
      check_z("lat_b16", 64'h0000_0000_0003_0000);
      check_lat("lat_b16", lat, EARLY ? 17 : 32);
      @(negedge clk);
      run_op(1'b1, 32'hDEAD_BEEF, 32'd0, lat, bcnt);
      check_z("lat_b0", 64'd0);
      check_lat("lat_b0", lat, EARLY ? 1 : 32);
      @(negedge clk);
   endtask

   task automatic test_random();
      int lat, bcnt;
      logic [31:0] av, bv;
      logic        s;
      logic signed [63:0] sa, sb;
      logic [63:0] exp;
      for (int i = 0; i < 40; i++) begin
         av = $urandom; bv = $urandom; s = 1'($urandom_range(0, 1));
         if (i % 8 == 0) bv = bv >> $urandom_range(0, 31);
         sa = s ? {{32{av[31]}}, av} : {32'd0, av};
         sb = s ? {{32{bv[31]}}, bv} : {32'd0, bv};
         exp = 64'(sa * sb);
         run_op(s, av, bv, lat, bcnt);
         check_z("random", exp);
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL random_single_done: done=%b required 0", done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_max();
      test_back_to_back();
      test_sign_mode();
      test_busy_ignore();
      test_reset_mid();
      test_latency();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
